// File: rtl/instr_fetch.sv
// Fetch stage of the 9-bit CPU: owns the PC, reads synchronous instruction memory and
// hands words to decode over valid/ready, with a 1-entry skid buffer, redirects and halt on dne.
module instr_fetch #(
  parameter int                PC_W     = 12,
  parameter int                INSTR_W  = 9,
  parameter logic [PC_W-1:0]   RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               imem_rd_en,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [PC_W-1:0]    dec_pc,
  input  logic               redirect_en,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               halted
);

  // {func, dne} is the all-ones encoding
  localparam logic [INSTR_W-1:0] DNE = '1;

  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

  state_t state_reg, state_next;

  logic [PC_W-1:0]    pc_reg;
  logic               inflight_reg;
  logic [PC_W-1:0]    inflight_pc_reg;
  logic               out_valid_reg;
  logic [INSTR_W-1:0] out_instr_reg;
  logic [PC_W-1:0]    out_pc_reg;
  logic               skid_valid_reg;
  logic [INSTR_W-1:0] skid_instr_reg;
  logic [PC_W-1:0]    skid_pc_reg;

  logic fetching;
  logic handshake;
  logic dne_accept;
  logic issue;

  // A returning word with an empty output register is presented straight from memory,
  // which gives the two-cycle start/redirect latency and full throughput.
  assign fetching   = (state_reg == FETCH);
  assign dec_valid  = fetching & (out_valid_reg | inflight_reg);
  assign dec_instr  = out_valid_reg ? out_instr_reg : (inflight_reg ? imem_data : '0);
  assign dec_pc     = out_valid_reg ? out_pc_reg    : (inflight_reg ? inflight_pc_reg : '0);
  assign handshake  = dec_valid & dec_ready;
  assign dne_accept = handshake & (dec_instr == DNE);
  assign issue      = fetching & !skid_valid_reg
                    & !(inflight_reg & dec_valid & !dec_ready) & !redirect_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, HALT: if (start)      state_next = FETCH;
      FETCH:      if (dne_accept) state_next = HALT;
      default:                    state_next = IDLE;
    endcase
  end

  always_comb begin
    imem_rd_en = issue;
    imem_addr  = issue ? pc_reg : '0;
    halted     = (state_reg == HALT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg          <= RESET_PC;
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= '0;
      out_valid_reg   <= 1'b0;
      out_instr_reg   <= '0;
      out_pc_reg      <= '0;
      skid_valid_reg  <= 1'b0;
      skid_instr_reg  <= '0;
      skid_pc_reg     <= '0;
    end else if (!fetching) begin
      if (start) pc_reg <= RESET_PC;
      inflight_reg   <= 1'b0;
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else if (dne_accept || redirect_en) begin
      // halt outranks a simultaneous redirect: the PC is left untouched
      if (!dne_accept) pc_reg <= redirect_pc;
      inflight_reg   <= 1'b0;
      out_valid_reg  <= 1'b0;
      skid_valid_reg <= 1'b0;
    end else begin
      if (issue) pc_reg <= pc_reg + 1'b1;
      inflight_reg    <= issue;
      inflight_pc_reg <= pc_reg;
      if (out_valid_reg) begin
        if (handshake) begin
          if (skid_valid_reg) begin
            out_instr_reg  <= skid_instr_reg;
            out_pc_reg     <= skid_pc_reg;
            skid_valid_reg <= 1'b0;
          end else if (inflight_reg) begin
            out_instr_reg <= imem_data;
            out_pc_reg    <= inflight_pc_reg;
          end else begin
            out_valid_reg <= 1'b0;
          end
        end else if (inflight_reg) begin
          skid_instr_reg <= imem_data;
          skid_pc_reg    <= inflight_pc_reg;
          skid_valid_reg <= 1'b1;
        end
      end else if (inflight_reg && !handshake) begin
        out_instr_reg <= imem_data;
        out_pc_reg    <= inflight_pc_reg;
        out_valid_reg <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus a random run, all checked against a
// queue of expected (pc, word) pairs derived from the memory image and control events.
module tb_instr_fetch;

  localparam int              PC_W   = 12;
  localparam int              INSTR_W = 9;
  localparam logic [PC_W-1:0] RST_PC = 12'hFFE;
  localparam logic [8:0]      DNE    = 9'h1FF;

  logic             clk = 1'b0;
  logic             rst, start, imem_rd_en, dec_valid, dec_ready, redirect_en, halted;
  logic [PC_W-1:0]  imem_addr, dec_pc, redirect_pc;
  logic [8:0]       imem_data, dec_instr;
  logic [8:0]       mem [0:4095];

  instr_fetch #(.PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(rst), .start(start),
    .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_data(imem_data),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr), .dec_pc(dec_pc),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc), .halted(halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (imem_rd_en) imem_data <= mem[imem_addr];

  typedef struct packed { logic [PC_W-1:0] pc; logic [8:0] instr; } exp_t;
  exp_t            exp_q[$];
  logic [PC_W-1:0] push_pc = '0;
  bit              push_done = 1'b1;
  bit              fetching = 1'b0, halted_m = 1'b0, dne_hs = 1'b0;
  int              n_cmp = 0, n_bad = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endfunction

  // The program from a given address is simply mem[a], mem[a+1], ... up to and including dne.
  function automatic void refill();
    while (!push_done && exp_q.size() < 16) begin
      exp_q.push_back('{pc: push_pc, instr: mem[push_pc]});
      if (mem[push_pc] == DNE) push_done = 1'b1;
      push_pc = push_pc + 12'd1;
    end
  endfunction

  function automatic void load_segment(logic [PC_W-1:0] a);
    exp_q.delete();
    push_pc   = a;
    push_done = 1'b0;
    refill();
  endfunction

  // Advance one clock; the inputs that were held during the finished cycle update the model.
  task automatic tick();
    @(posedge clk);
    if (dne_hs) begin
      fetching = 1'b0; halted_m = 1'b1; exp_q.delete(); push_done = 1'b1;
    end else if (fetching && redirect_en) begin
      load_segment(redirect_pc);
    end else if (!fetching && start) begin
      fetching = 1'b1; halted_m = 1'b0; load_segment(RST_PC);
    end
    dne_hs = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; redirect_en = 1'b0;
    #1;
    chk("rst_valid", 32'(dec_valid), 32'(0));
    chk("rst_instr", 32'(dec_instr), 32'(0));
    chk("rst_pc",    32'(dec_pc),    32'(0));
    chk("rst_rd_en", 32'(imem_rd_en), 32'(0));
    chk("rst_addr",  32'(imem_addr), 32'(0));
    chk("rst_halted", 32'(halted),   32'(0));
    fetching = 1'b0; halted_m = 1'b0; exp_q.delete(); push_done = 1'b1; dne_hs = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic fill_mem(int dne_den);
    logic [8:0] w;
    for (int i = 0; i < 4096; i++) begin
      w = 9'($urandom_range(0, 510));
      if (dne_den > 0 && $urandom_range(0, dne_den - 1) == 0) w = DNE;
      mem[i] = w;
    end
  endtask

  task automatic wait_halt(string name);
    for (int i = 0; i < 60 && !halted; i++) tick();
    chk(name, 32'(halted), 32'(1));
  endtask

  // Monitor: scoreboard pops on every handshake, plus per-cycle state and stall checks.
  initial begin
    exp_t            e;
    logic            prev_stall = 1'b0;
    logic [PC_W-1:0] prev_pc = '0;
    logic [8:0]      prev_instr = '0;
    forever begin
      @(negedge clk);
      chk("halted", 32'(halted), 32'(halted_m));
      if (!fetching) begin
        chk("stopped_valid", 32'(dec_valid), 32'(0));
        chk("stopped_rd_en", 32'(imem_rd_en), 32'(0));
      end
      if (prev_stall && !rst) begin
        chk("stall_valid", 32'(dec_valid), 32'(1));
        chk("stall_pc",    32'(dec_pc),    32'(prev_pc));
        chk("stall_instr", 32'(dec_instr), 32'(prev_instr));
      end
      if (dec_valid && dec_ready && !rst) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_word: got pc %0h instr %0h, required no delivery", dec_pc, dec_instr);
        end else begin
          e = exp_q.pop_front();
          chk("dec_pc",    32'(dec_pc),    32'(e.pc));
          chk("dec_instr", 32'(dec_instr), 32'(e.instr));
          if (e.instr == DNE) dne_hs = 1'b1;
          refill();
        end
      end
      prev_stall = dec_valid && !dec_ready && !rst && !(redirect_en && fetching);
      prev_pc    = dec_pc;
      prev_instr = dec_instr;
    end
  end

  initial begin
    logic [PC_W-1:0] epc;
    rst = 1'b1; start = 1'b0; dec_ready = 1'b1; redirect_en = 1'b0; redirect_pc = '0;
    imem_data = '0;
    fill_mem(0);
    do_reset();

    // Linear program across the address wrap, dne at 0x001, decode always ready
    mem[12'hFFE] = 9'h015; mem[12'hFFF] = 9'h027; mem[12'h000] = 9'h0A3; mem[12'h001] = DNE;
    start = 1'b1; tick(); start = 1'b0;
    @(negedge clk);
    chk("c1_valid", 32'(dec_valid), 32'(0));
    chk("c1_rd_en", 32'(imem_rd_en), 32'(1));
    chk("c1_addr",  32'(imem_addr), 32'(RST_PC));
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk);
      epc = RST_PC + 12'(k);
      chk("stream_valid", 32'(dec_valid), 32'(1));
      chk("stream_pc",    32'(dec_pc),    32'(epc));
    end
    tick();
    @(negedge clk);
    chk("halt_flag",  32'(halted),     32'(1));
    chk("halt_rd_en", 32'(imem_rd_en), 32'(0));
    chk("halt_valid", 32'(dec_valid),  32'(0));

    // Stall after the first word, then release
    dec_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    @(negedge clk);
    chk("stall_first", 32'(dec_pc), 32'(RST_PC));
    repeat (4) begin
      tick();
      @(negedge clk);
      chk("stall_hold", 32'(dec_pc), 32'(RST_PC));
    end
    tick();
    dec_ready = 1'b1;
    wait_halt("stall_run_halt");

    // Redirect to 0x040 while streaming at pc 5
    mem[12'h001] = 9'h055; mem[12'h043] = DNE;
    start = 1'b1; tick(); start = 1'b0;
    repeat (8) tick();
    redirect_en = 1'b1; redirect_pc = 12'h040;
    @(negedge clk);
    chk("redir_at_pc", 32'(dec_pc), 32'h005);
    tick();
    redirect_en = 1'b0;
    @(negedge clk);
    chk("redir_gap", 32'(dec_valid), 32'(0));
    tick();
    @(negedge clk);
    chk("redir_tgt_valid", 32'(dec_valid), 32'(1));
    chk("redir_tgt_pc",    32'(dec_pc),    32'h040);
    wait_halt("redir_halt");

    // Reset while stalled with the skid buffer full
    mem[12'h001] = DNE;
    dec_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    chk("skid_full_rd_en", 32'(imem_rd_en), 32'(0));
    chk("skid_full_pc",    32'(dec_pc),     32'(RST_PC));
    tick();
    do_reset();
    @(negedge clk);
    chk("post_rst_valid", 32'(dec_valid), 32'(0));

    // dne handshake coinciding with a redirect: halt wins
    dec_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    redirect_en = 1'b1; redirect_pc = 12'h080;
    @(negedge clk);
    chk("dne_pc",    32'(dec_pc),    32'h001);
    chk("dne_instr", 32'(dec_instr), 32'(DNE));
    tick();
    redirect_en = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("halt_win_flag",  32'(halted),     32'(1));
      chk("halt_win_rd_en", 32'(imem_rd_en), 32'(0));
      tick();
    end
    start = 1'b1; tick(); start = 1'b0;
    tick();
    @(negedge clk);
    chk("restart_valid", 32'(dec_valid), 32'(1));
    chk("restart_pc",    32'(dec_pc),    32'(RST_PC));
    wait_halt("restart_halt");

    // Random traffic: random memory with sparse dne, random ready/redirect/start/reset
    fill_mem(32);
    for (int c = 0; c < 3000; c++) begin
      tick();
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        dec_ready   = ($urandom_range(0, 3) != 0);
        redirect_en = ($urandom_range(0, 19) == 0);
        redirect_pc = 12'($urandom);
        start       = ($urandom_range(0, 5) == 0);
      end
    end
    start = 1'b0; redirect_en = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
